rho_lane_rotate: RTL and testbench

- Parametrised successor to the bit-serial Keccak rho step.
- Rotates every lane of a 5x5xLANE_W state by its rho offset, LANES_PER_CYCLE lanes per clock, with no per-bit serialisation.
- Adds an inverse (rotate-right) mode for inverse-permutation use, a start/busy/done handshake and a registered output state.
- Sits between the theta and pi stages of the permutation datapath.

---
 rtl/rho_lane_rotate_pkg.sv | 28 ++
 rtl/rho_lane_rotate_if.sv | 23 ++
 rtl/rho_lane_rotate_lane_rotator.sv | 30 +++
 rtl/rho_lane_rotate.sv | 93 +++++++++
 tb/tb_rho_lane_rotate.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rho_lane_rotate_pkg.sv
// Shared Keccak constants and state encoding for the parallel rho lane rotator.
// Lane index L = j*5 + i, so bit z of lane L sits at flat index z*25 + L.
package rho_lane_rotate_pkg;

  localparam int NUM_ROW    = 5;
  localparam int NUM_COLUMN = 5;
  localparam int NUM_LANES  = NUM_ROW * NUM_COLUMN;

  localparam int RHO_OFFSET [NUM_ROW][NUM_COLUMN] = '{
    '{ 0, 36,  3, 41, 18},
    '{ 1, 44, 10, 45,  2},
    '{62,  6, 43, 15, 61},
    '{28, 55, 25, 21, 56},
    '{27, 20, 39,  8, 14}
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROTATE,
    ST_DONE
  } state_t;

  // Only evaluated at elaboration to build the per-lane amount table.
  function automatic int rhoOffsetOfLane(input int lane);
    return RHO_OFFSET[lane % NUM_ROW][lane / NUM_ROW];
  endfunction

endpackage

// File: rtl/rho_lane_rotate_if.sv
// Start/busy/done handshake and state buses of the rho lane rotator.
interface rho_lane_rotate_if #(
  parameter int LANE_W = 64
) ();

  logic                  start;
  logic                  inverse;
  logic [25*LANE_W-1:0]  data_in;
  logic                  busy;
  logic                  done;
  logic [25*LANE_W-1:0]  data_out;

  modport master (
    output start, inverse, data_in,
    input  busy, done, data_out
  );

  modport slave (
    input  start, inverse, data_in,
    output busy, done, data_out
  );

endinterface

// File: rtl/rho_lane_rotate_lane_rotator.sv
// Combinational log2(LANE_W)-stage barrel rotator for a single lane.
// A right rotation by r is done as a left rotation by the two's complement of r.
module lane_rotator #(
  parameter int LANE_W = 64,
  localparam int SHW = (LANE_W > 1) ? $clog2(LANE_W) : 1
) (
  input  logic [LANE_W-1:0] i_lane,
  input  logic [SHW-1:0]    i_amount,
  input  logic              i_dir,
  output logic [LANE_W-1:0] o_lane
);

  logic [SHW-1:0]             w_leftAmt;
  logic [SHW:0][LANE_W-1:0]   w_stage;

  assign w_leftAmt  = i_dir ? (SHW'(0) - i_amount) : i_amount;
  assign w_stage[0] = i_lane;

  for (genvar s = 0; s < SHW; s++) begin : g_stage
    logic [LANE_W-1:0] w_rot;
    for (genvar z = 0; z < LANE_W; z++) begin : g_bit
      localparam int SRC = (z - ((1 << s) % LANE_W) + LANE_W) % LANE_W;
      assign w_rot[z] = w_stage[s][SRC];
    end
    assign w_stage[s+1] = w_leftAmt[s] ? w_rot : w_stage[s];
  end

  assign o_lane = w_stage[SHW];

endmodule

// File: rtl/rho_lane_rotate.sv
// Keccak rho step: rotates LANES_PER_CYCLE lanes per clock from a frozen source
// copy into a registered destination state, with an optional inverse direction.
module rho_lane_rotate
  import rho_lane_rotate_pkg::*;
#(
  parameter int LANE_W          = 64,
  parameter int LANES_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  rho_lane_rotate_if.slave bus
);

  localparam int          SHW        = (LANE_W > 1) ? $clog2(LANE_W) : 1;
  localparam int          NUM_GROUPS = NUM_LANES / LANES_PER_CYCLE;
  localparam logic [4:0]  LAST_GROUP = 5'(NUM_GROUPS - 1);
  localparam logic [4:0]  LPC5       = 5'(LANES_PER_CYCLE);

  state_t             r_state;
  state_t             w_nextState;
  logic [4:0]         r_count;
  logic               r_mode;
  logic [LANE_W-1:0]  r_srcLane [NUM_LANES];
  logic [LANE_W-1:0]  r_dstLane [NUM_LANES];
  logic [LANE_W-1:0]  w_inLane  [NUM_LANES];
  logic [SHW-1:0]     w_amtTable [NUM_LANES];
  logic [4:0]         w_laneIdx [LANES_PER_CYCLE];
  logic [LANE_W-1:0]  w_rotLane [LANES_PER_CYCLE];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign w_amtTable[l] = SHW'(rhoOffsetOfLane(l) & (LANE_W - 1));
    for (genvar z = 0; z < LANE_W; z++) begin : g_bit
      assign w_inLane[l][z]                  = bus.data_in[z*NUM_LANES + l];
      assign bus.data_out[z*NUM_LANES + l]   = r_dstLane[l][z];
    end
  end

  // The counter selects which group of source lanes feeds the parallel rotators.
  for (genvar k = 0; k < LANES_PER_CYCLE; k++) begin : g_rot
    assign w_laneIdx[k] = r_count * LPC5 + 5'(k);
    lane_rotator #(.LANE_W(LANE_W)) u_rot (
      .i_lane   (r_srcLane[w_laneIdx[k]]),
      .i_amount (w_amtTable[w_laneIdx[k]]),
      .i_dir    (r_mode),
      .o_lane   (w_rotLane[k])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (bus.start) w_nextState = ST_ROTATE;
      ST_ROTATE: if (r_count == LAST_GROUP) w_nextState = ST_DONE;
      ST_DONE:   w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_mode  <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
        r_srcLane[l] <= '0;
        r_dstLane[l] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_count <= '0;
            r_mode  <= bus.inverse;
            for (int l = 0; l < NUM_LANES; l++) r_srcLane[l] <= w_inLane[l];
          end
        end
        ST_ROTATE: begin
          for (int k = 0; k < LANES_PER_CYCLE; k++) r_dstLane[w_laneIdx[k]] <= w_rotLane[k];
          r_count <= r_count + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != ST_IDLE);
  assign bus.done = (r_state == ST_DONE);

endmodule

// File: tb/tb_rho_lane_rotate.sv
// Scoreboard bench for rho_lane_rotate across several LANE_W / LANES_PER_CYCLE builds.
module tb_rho_lane_rotate;

  localparam int NI = 6;
  localparam int CFG_W   [NI] = '{64, 64, 64,  8, 32, 16};
  localparam int CFG_LPC [NI] = '{ 1,  5, 25,  1,  5, 25};
  localparam int OFFS [25] = '{ 0, 36,  3, 41, 18,
                                1, 44, 10, 45,  2,
                               62,  6, 43, 15, 61,
                               28, 55, 25, 21, 56,
                               27, 20, 39,  8, 14};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          startV  [NI];
  logic          invV    [NI];
  logic [1599:0] dataIn  [NI];
  logic          busyV   [NI];
  logic          doneV   [NI];
  logic [1599:0] dataOut [NI];

  int checks   = 0;
  int failures = 0;
  logic [1599:0] sbQ [$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W   = CFG_W[g];
    localparam int LPC = CFG_LPC[g];
    rho_lane_rotate_if #(.LANE_W(W)) ifc ();
    assign ifc.start   = startV[g];
    assign ifc.inverse = invV[g];
    assign ifc.data_in = dataIn[g][25*W-1:0];
    assign busyV[g]    = ifc.busy;
    assign doneV[g]    = ifc.done;
    assign dataOut[g]  = 1600'(ifc.data_out);
    rho_lane_rotate #(.LANE_W(W), .LANES_PER_CYCLE(LPC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
    );
  end

  function automatic logic [1599:0] golden(input logic [1599:0] d, input int w, input logic inv);
    logic [1599:0] o;
    int r, src;
    o = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        r = OFFS[i*5 + j] % w;
        for (int z = 0; z < w; z++) begin
          src = inv ? (z + r) % w : (z - r + w) % w;
          o[z*25 + j*5 + i] = d[src*25 + j*5 + i];
        end
      end
    return o;
  endfunction

  function automatic logic [1599:0] randState(input int w);
    logic [1599:0] v;
    for (int k = 0; k < 50; k++) v[k*32 +: 32] = $urandom;
    for (int b = 25*w; b < 1600; b++) v[b] = 1'b0;
    return v;
  endfunction

  function automatic logic [63:0] getLane(input logic [1599:0] v, input int lane, input int w);
    logic [63:0] r;
    r = '0;
    for (int z = 0; z < w; z++) r[z] = v[z*25 + lane];
    return r;
  endfunction

  function automatic logic [1599:0] setLane(input logic [1599:0] v, input int lane, input int w,
                                            input logic [63:0] val);
    logic [1599:0] o;
    o = v;
    for (int z = 0; z < w; z++) o[z*25 + lane] = val[z];
    return o;
  endfunction

  // Leaves the caller at the falling edge of the first cycle after acceptance,
  // with the inputs scrambled so a non-frozen source copy would be exposed.
  task automatic startOp(input int idx, input logic [1599:0] d, input logic inv);
    sbQ.push_back(golden(d, CFG_W[idx], inv));
    @(negedge clk);
    dataIn[idx] = d;
    invV[idx]   = inv;
    startV[idx] = 1'b1;
    @(negedge clk);
    startV[idx] = 1'b0;
    invV[idx]   = ~inv;
    dataIn[idx] = randState(CFG_W[idx]);
  endtask

  task automatic waitDone(input int idx, input string name, output logic [1599:0] got);
    logic [1599:0] exp;
    bit seen;
    int c;
    seen = 0;
    c    = 0;
    exp  = sbQ.pop_front();
    while (!seen && c < 64) begin
      if (doneV[idx] === 1'b1) seen = 1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    got = dataOut[idx];
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL %s: done never seen within 64 cycles (inst %0d)", name, idx);
    end else if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: inst %0d data_out differs in %0d bits, got[63:0]=%h exp[63:0]=%h",
               name, idx, $countones(got ^ exp), got[63:0], exp[63:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int n = 0; n < NI; n++) begin
      checks += 3;
      if (busyV[n] !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy inst %0d: got %b exp 0", n, busyV[n]); end
      if (doneV[n] !== 1'b0) begin failures++; $display("[TB] FAIL reset_done inst %0d: got %b exp 0", n, doneV[n]); end
      if (dataOut[n] !== '0) begin failures++; $display("[TB] FAIL reset_data inst %0d: got[63:0]=%h exp 0", n, dataOut[n][63:0]); end
    end
    rst = 1'b1;
  endtask

  task automatic test_single_bit();
    logic [1599:0] d, exp, sbExp;
    d = '0;
    d[5] = 1'b1;
    exp = '0;
    exp[36*25 + 5] = 1'b1;
    startOp(0, d, 1'b0);
    sbExp = sbQ.pop_front();
    for (int c = 1; c <= 26; c++) begin
      if (c > 1) @(negedge clk);
      checks += 2;
      if (busyV[0] !== 1'b1) begin failures++; $display("[TB] FAIL single_busy cycle T+%0d: got %b exp 1", c, busyV[0]); end
      if (doneV[0] !== (c == 26)) begin failures++; $display("[TB] FAIL single_done cycle T+%0d: got %b exp %b", c, doneV[0], c == 26); end
    end
    checks += 2;
    if (dataOut[0] !== exp) begin
      failures++;
      $display("[TB] FAIL single_bit_data: got %0d set bits, exp only bit %0d", $countones(dataOut[0]), 36*25 + 5);
    end
    if (dataOut[0] !== sbExp) begin
      failures++;
      $display("[TB] FAIL single_bit_model: differs in %0d bits", $countones(dataOut[0] ^ sbExp));
    end
    @(negedge clk);
    checks += 2;
    if (busyV[0] !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_after: got %b exp 0", busyV[0]); end
    if (doneV[0] !== 1'b0) begin failures++; $display("[TB] FAIL single_done_after: got %b exp 0", doneV[0]); end
  endtask

  task automatic test_narrow();
    logic [1599:0] d, got;
    logic [63:0] l5, l2, l0;
    d = randState(8);
    d = setLane(d, 5, 8, 64'h01);
    d = setLane(d, 2, 8, 64'h01);
    d = setLane(d, 0, 8, 64'hA5);
    startOp(3, d, 1'b0);
    waitDone(3, "narrow_model", got);
    l5 = getLane(got, 5, 8);
    l2 = getLane(got, 2, 8);
    l0 = getLane(got, 0, 8);
    checks += 3;
    if (l5 !== 64'h10) begin failures++; $display("[TB] FAIL narrow_lane01: got %h exp 10", l5[7:0]); end
    if (l2 !== 64'h40) begin failures++; $display("[TB] FAIL narrow_lane20: got %h exp 40", l2[7:0]); end
    if (l0 !== 64'hA5) begin failures++; $display("[TB] FAIL narrow_lane00: got %h exp a5", l0[7:0]); end
  endtask

  task automatic test_round_trip();
    logic [1599:0] orig, mid, fin;
    for (int n = 0; n < 3; n++) begin
      orig = randState(CFG_W[n]);
      startOp(n, orig, 1'b0);
      waitDone(n, "trip_forward", mid);
      startOp(n, mid, 1'b1);
      waitDone(n, "trip_inverse", fin);
      checks++;
      if (fin !== orig) begin
        failures++;
        $display("[TB] FAIL round_trip inst %0d: differs in %0d bits from original", n, $countones(fin ^ orig));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1599:0] d, exp;
    int doneAt [3];
    int nDone, cyc;
    d = randState(64);
    for (int k = 0; k < 3; k++) sbQ.push_back(golden(d, 64, 1'b0));
    nDone = 0;
    cyc   = 0;
    @(negedge clk);
    dataIn[0] = d;
    invV[0]   = 1'b0;
    startV[0] = 1'b1;
    while (nDone < 3 && cyc < 3*27 + 20) begin
      @(negedge clk);
      cyc++;
      if (doneV[0] === 1'b1) begin
        doneAt[nDone] = cyc;
        exp = sbQ.pop_front();
        checks++;
        if (dataOut[0] !== exp) begin
          failures++;
          $display("[TB] FAIL b2b_data op %0d: differs in %0d bits", nDone, $countones(dataOut[0] ^ exp));
        end
        nDone++;
        if (nDone == 3) startV[0] = 1'b0;
      end
      invV[0] = (busyV[0] === 1'b1) ? ~invV[0] : 1'b0;
    end
    startV[0] = 1'b0;
    invV[0]   = 1'b0;
    checks++;
    if (nDone != 3) begin
      failures++;
      $display("[TB] FAIL b2b_count: got %0d done pulses exp 3", nDone);
      sbQ.delete();
    end else begin
      checks += 2;
      if (doneAt[1] - doneAt[0] != 27) begin failures++; $display("[TB] FAIL b2b_period1: got %0d exp 27", doneAt[1] - doneAt[0]); end
      if (doneAt[2] - doneAt[1] != 27) begin failures++; $display("[TB] FAIL b2b_period2: got %0d exp 27", doneAt[2] - doneAt[1]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [1599:0] got;
    startOp(0, randState(64), 1'b0);
    repeat (9) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    sbQ.delete();
    checks += 3;
    if (busyV[0] !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy: got %b exp 0", busyV[0]); end
    if (doneV[0] !== 1'b0) begin failures++; $display("[TB] FAIL midreset_done: got %b exp 0", doneV[0]); end
    if (dataOut[0] !== '0) begin failures++; $display("[TB] FAIL midreset_data: got[63:0]=%h exp 0", dataOut[0][63:0]); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    startOp(0, randState(64), 1'b1);
    waitDone(0, "after_reset", got);
  endtask

  task automatic test_random_model();
    logic [1599:0] got;
    for (int n = 0; n < NI; n++)
      for (int k = 0; k < 120; k++) begin
        startOp(n, randState(CFG_W[n]), k[0]);
        waitDone(n, "random_model", got);
      end
  endtask

  initial begin
    for (int n = 0; n < NI; n++) begin
      startV[n] = 1'b0;
      invV[n]   = 1'b0;
      dataIn[n] = '0;
    end
    test_reset();
    test_single_bit();
    test_narrow();
    test_round_trip();
    test_back_to_back();
    test_reset_mid();
    test_random_model();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
